mpsoc_bb_ext_arbiter: RTL and testbench

Parametrised round-robin arbiter that lets the NODES tiles of a 2D/3D MSP430 mesh share one external Blackbone memory port instead of each tile exporting its own. Sits at the top level between the per-tile bb_ext_* buses and a single memory macro or off-chip bridge. It adds a per-node acknowledge so tiles stall while another node owns the port. It supports a configurable fixed memory read latency.

---
 rtl/mpsoc_bb_ext_arbiter_if.sv | 39 +++
 rtl/mpsoc_bb_ext_arbiter.sv | 121 ++++++++++++
 tb/tb_mpsoc_bb_ext_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mpsoc_bb_ext_arbiter_if.sv
// ---------------------------------------------------------------------------
// mpsoc_bb_ext_arbiter_if
// Bundles the per-tile Blackbone request buses and the single shared memory
// port that the round-robin arbiter multiplexes them onto.
//   bb_ext_addr_i / din_i / en_i / we_i : per-node request (NODES lanes)
//   bb_ext_dout_o / ack_o               : per-node response (broadcast data,
//                                         one-hot ack)
//   mem_addr / mem_din / mem_en / mem_we: shared memory request
//   mem_dout                            : shared memory read data
// Modports: master = arbiter view, slave = tiles + memory view.
// ---------------------------------------------------------------------------
interface mpsoc_bb_ext_arbiter_if #(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int NODES = 8
);
  logic [NODES-1:0][AW-1:0] bb_ext_addr_i;
  logic [NODES-1:0][DW-1:0] bb_ext_din_i;
  logic [NODES-1:0]         bb_ext_en_i;
  logic [NODES-1:0]         bb_ext_we_i;
  logic [NODES-1:0][DW-1:0] bb_ext_dout_o;
  logic [NODES-1:0]         bb_ext_ack_o;

  logic [AW-1:0]            mem_addr;
  logic [DW-1:0]            mem_din;
  logic                     mem_en;
  logic                     mem_we;
  logic [DW-1:0]            mem_dout;

  modport master (
    input  bb_ext_addr_i, bb_ext_din_i, bb_ext_en_i, bb_ext_we_i, mem_dout,
    output bb_ext_dout_o, bb_ext_ack_o, mem_addr, mem_din, mem_en, mem_we
  );

  modport slave (
    output bb_ext_addr_i, bb_ext_din_i, bb_ext_en_i, bb_ext_we_i, mem_dout,
    input  bb_ext_dout_o, bb_ext_ack_o, mem_addr, mem_din, mem_en, mem_we
  );
endinterface

// File: rtl/mpsoc_bb_ext_arbiter.sv
// ---------------------------------------------------------------------------
// mpsoc_bb_ext_arbiter
// Round-robin arbiter sharing one external Blackbone memory port among NODES
// mesh tiles. One transaction at a time: IDLE -> ISSUE -> (WAIT) -> ACK.
// Reads see mem_dout RD_LAT cycles after the mem_en cycle.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   bus  : mpsoc_bb_ext_arbiter_if.master (per-node requests, shared memory)
// ---------------------------------------------------------------------------
module mpsoc_bb_ext_arbiter #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int NODES  = 8,
  parameter int RD_LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  mpsoc_bb_ext_arbiter_if.master bus
);

  localparam int PW = (NODES > 1) ? $clog2(NODES) : 1;
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  state_t           state_q;
  logic [PW-1:0]    ptr_q;
  logic [PW-1:0]    gnt_q;
  logic [PW-1:0]    gnt_d;
  logic [PW-1:0]    idx;
  logic             req_any;
  logic [CW-1:0]    cnt_q;
  logic [DW-1:0]    rdata_q;
  logic [AW-1:0]    mem_addr_q;
  logic [DW-1:0]    mem_din_q;
  logic             mem_en_q;
  logic             mem_we_q;
  logic [NODES-1:0] ack_q;

  // Rotating priority: scan from the farthest offset down to offset 0 so the
  // last hit (closest at/after ptr) wins.
  always_comb begin
    gnt_d   = ptr_q;
    idx     = '0;
    req_any = 1'b0;
    for (int i = NODES - 1; i >= 0; i--) begin
      idx = PW'((int'(ptr_q) + i) % NODES);
      if (bus.bb_ext_en_i[idx]) begin
        gnt_d   = idx;
        req_any = 1'b1;
      end
    end
  end

  // The mem_* registers double as the request registers: they are loaded
  // when a grant is made and hold afterwards, only mem_en qualifies them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      gnt_q      <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      ack_q      <= '0;
    end else begin
      mem_en_q <= 1'b0;
      ack_q    <= '0;
      case (state_q)
        IDLE: begin
          if (req_any) begin
            gnt_q      <= gnt_d;
            mem_addr_q <= bus.bb_ext_addr_i[gnt_d];
            mem_din_q  <= bus.bb_ext_din_i[gnt_d];
            mem_we_q   <= bus.bb_ext_we_i[gnt_d];
            mem_en_q   <= 1'b1;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_we_q) begin
            ack_q[gnt_q] <= 1'b1;
            state_q      <= ACK;
          end else begin
            // Reads always spend RD_LAT cycles in WAIT so the capture edge is
            // the end of cycle issue+RD_LAT, where mem_dout is valid; this
            // keeps the read-to-read spacing at RD_LAT+3 for every latency.
            cnt_q   <= CW'(RD_LAT - 1);
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            rdata_q      <= bus.mem_dout;
            ack_q[gnt_q] <= 1'b1;
            state_q      <= ACK;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ACK: begin
          ptr_q   <= (int'(gnt_q) == NODES - 1) ? '0 : gnt_q + 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_din       = mem_din_q;
  assign bus.mem_en        = mem_en_q;
  assign bus.mem_we        = mem_we_q;
  assign bus.bb_ext_ack_o  = ack_q;
  assign bus.bb_ext_dout_o = {NODES{rdata_q}};

endmodule

// File: tb/tb_mpsoc_bb_ext_arbiter.sv
module tb_mpsoc_bb_ext_arbiter;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int NODES = 8;
  localparam int NI    = 3;   // instances: RD_LAT 2, 1, 8

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : (k == 1) ? 1 : 8;
  endfunction

  // Memory contents as a pure function of the address.
  function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
    if (a == 32'h40) return 32'h1234_5678;
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  // Per-instance stimulus and observation
  logic [NODES-1:0]         en_s     [NI];
  logic [NODES-1:0]         we_s     [NI];
  logic [NODES-1:0][AW-1:0] addr_s   [NI];
  logic [NODES-1:0][DW-1:0] din_s    [NI];
  logic [NODES-1:0]         ack_s    [NI];
  logic [NODES-1:0][DW-1:0] dout_v   [NI];
  logic                     mem_en_s [NI];
  logic                     mem_we_s [NI];
  logic [AW-1:0]            mem_addr_s [NI];
  logic [DW-1:0]            mem_din_s  [NI];

  for (genvar k = 0; k < NI; k++) begin : g_inst
    localparam int LAT = (k == 0) ? 2 : (k == 1) ? 1 : 8;
    logic [DW-1:0] rpipe [LAT];
    mpsoc_bb_ext_arbiter_if #(.AW(AW), .DW(DW), .NODES(NODES)) bus ();

    assign bus.bb_ext_addr_i = addr_s[k];
    assign bus.bb_ext_din_i  = din_s[k];
    assign bus.bb_ext_en_i   = en_s[k];
    assign bus.bb_ext_we_i   = we_s[k];
    assign bus.mem_dout      = rpipe[LAT-1];
    assign ack_s[k]          = bus.bb_ext_ack_o;
    assign dout_v[k]         = bus.bb_ext_dout_o;
    assign mem_en_s[k]       = bus.mem_en;
    assign mem_we_s[k]       = bus.mem_we;
    assign mem_addr_s[k]     = bus.mem_addr;
    assign mem_din_s[k]      = bus.mem_din;

    // Fixed-latency memory: read data valid exactly LAT cycles after the
    // mem_en cycle, junk otherwise.
    always @(posedge clk) begin
      rpipe[0] <= (bus.mem_en === 1'b1 && bus.mem_we === 1'b0) ?
                  mem_fn(bus.mem_addr) : {16'hDEAD, cyc[15:0]};
      for (int i = 1; i < LAT; i++) rpipe[i] <= rpipe[i-1];
    end

    mpsoc_bb_ext_arbiter #(.AW(AW), .DW(DW), .NODES(NODES), .RD_LAT(LAT)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );
  end

  // Current request set
  logic [NODES-1:0]         req_mask;
  logic [NODES-1:0]         req_we;
  logic [NODES-1:0][AW-1:0] req_addr;
  logic [NODES-1:0][DW-1:0] req_din;

  // Reference state per instance
  int            exp_ptr  [NI];
  logic [DW-1:0] exp_dout [NI];

  // Observation log
  int               n_ack, n_iss, n_bcast_bad;
  int               ack_cyc  [64];
  logic [NODES-1:0] ack_vec  [64];
  logic [DW-1:0]    ack_dout [64];
  int               iss_cyc  [64];
  logic [AW-1:0]    iss_addr [64];
  logic [DW-1:0]    iss_din  [64];
  logic             iss_we   [64];

  // Model predictions
  int            ne;
  int            e_node [64];
  int            e_iss  [64];
  int            e_ack  [64];
  logic [DW-1:0] e_dout [64];

  task automatic rand_req(input logic [NODES-1:0] mask, input int we_mode);
    req_mask = mask;
    for (int n = 0; n < NODES; n++) begin
      req_addr[n] = $urandom & 32'h0000_FFFC;
      req_din[n]  = $urandom;
      req_we[n]   = (we_mode == 2) ? 1'($urandom_range(0, 1)) : 1'(we_mode);
    end
  endtask

  // Reference: serve pending nodes in rotating order from ptr; a grant in
  // IDLE cycle t issues at t+1 and acks at t+2 (+lat for reads); the next
  // IDLE is the cycle after the ack.
  task automatic predict(input int k);
    int p = exp_ptr[k];
    int t = 0;
    int g;
    logic [NODES-1:0] pend = req_mask;
    logic [DW-1:0] d = exp_dout[k];
    ne = 0;
    while (pend != '0) begin
      g = -1;
      for (int i = 0; i < NODES; i++)
        if (g < 0 && pend[(p + i) % NODES]) g = (p + i) % NODES;
      if (!req_we[g]) d = mem_fn(req_addr[g]);
      e_node[ne] = g;
      e_iss[ne]  = t + 1;
      e_ack[ne]  = t + 2 + (req_we[g] ? 0 : lat_of(k));
      e_dout[ne] = d;
      pend[g]    = 1'b0;
      p          = (g + 1) % NODES;
      t          = e_ack[ne] + 1;
      ne++;
    end
    exp_ptr[k]  = p;
    exp_dout[k] = d;
  endtask

  // Raise the request set on instance k (called just after a negedge, which
  // makes the current cycle cycle 0), hold each node until its ack, log.
  task automatic run_batch(input int k);
    int budget = NODES * (lat_of(k) + 3) + 16;
    int tail = 4;
    n_ack = 0; n_iss = 0; n_bcast_bad = 0;
    we_s[k] = req_we; addr_s[k] = req_addr; din_s[k] = req_din;
    en_s[k] = req_mask;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (mem_en_s[k] === 1'b1 && n_iss < 64) begin
        iss_cyc[n_iss] = c; iss_addr[n_iss] = mem_addr_s[k];
        iss_din[n_iss] = mem_din_s[k]; iss_we[n_iss] = mem_we_s[k];
        n_iss++;
      end
      if (ack_s[k] !== '0 && n_ack < 64) begin
        ack_cyc[n_ack] = c; ack_vec[n_ack] = ack_s[k]; ack_dout[n_ack] = dout_v[k][0];
        for (int n = 1; n < NODES; n++) if (dout_v[k][n] !== dout_v[k][0]) n_bcast_bad++;
        n_ack++;
        en_s[k] = en_s[k] & ~ack_s[k];
      end
      if (en_s[k] == '0) begin
        tail--;
        if (tail == 0) break;
      end
    end
    if (en_s[k] != '0) begin
      tests_run++; tests_failed++;
      $display("FAIL timeout inst%0d: pending=%b, required none pending", k, en_s[k]);
      en_s[k] = '0;
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < NI; k++) begin exp_ptr[k] = 0; exp_dout[k] = '0; end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      tests_run++;
      if (ack_s[k] !== '0 || dout_v[k] !== '0 || mem_en_s[k] !== 1'b0 || mem_we_s[k] !== 1'b0 ||
          mem_addr_s[k] !== '0 || mem_din_s[k] !== '0) begin
        tests_failed++;
        $display("FAIL reset inst%0d: ack=%b en=%b we=%b addr=%h din=%h dout0=%h, required all zero",
                 k, ack_s[k], mem_en_s[k], mem_we_s[k], mem_addr_s[k], mem_din_s[k], dout_v[k][0]);
      end
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_write();
    logic [DW-1:0] prev = exp_dout[0];
    rand_req(8'b0000_1000, 1);
    req_addr[3] = 32'h100; req_din[3] = 32'hDEAD_BEEF;
    predict(0);
    run_batch(0);
    tests_run++;
    if (n_iss !== 1 || iss_cyc[0] !== 1 || iss_addr[0] !== 32'h100 || iss_din[0] !== 32'hDEAD_BEEF || iss_we[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL wr_issue: n=%0d cyc=%0d addr=%h din=%h we=%b, required n=1 cyc=1 addr=100 din=deadbeef we=1",
               n_iss, iss_cyc[0], iss_addr[0], iss_din[0], iss_we[0]);
    end
    tests_run++;
    if (n_ack !== 1 || ack_cyc[0] !== 2 || ack_vec[0] !== 8'b0000_1000 || ack_dout[0] !== prev) begin
      tests_failed++;
      $display("FAIL wr_ack: n=%0d cyc=%0d vec=%b dout=%h, required n=1 cyc=2 vec=00001000 dout=%h",
               n_ack, ack_cyc[0], ack_vec[0], ack_dout[0], prev);
    end
  endtask

  task automatic test_single_read();
    rand_req(8'b0000_0001, 0);
    req_addr[0] = 32'h40;
    predict(0);
    run_batch(0);
    tests_run++;
    if (n_iss !== 1 || iss_cyc[0] !== 1 || iss_addr[0] !== 32'h40 || iss_we[0] !== 1'b0) begin
      tests_failed++;
      $display("FAIL rd_issue: n=%0d cyc=%0d addr=%h we=%b, required n=1 cyc=1 addr=40 we=0",
               n_iss, iss_cyc[0], iss_addr[0], iss_we[0]);
    end
    tests_run++;
    if (n_ack !== 1 || ack_cyc[0] !== 4 || ack_vec[0] !== 8'b0000_0001 || ack_dout[0] !== 32'h1234_5678) begin
      tests_failed++;
      $display("FAIL rd_ack: n=%0d cyc=%0d vec=%b dout=%h, required n=1 cyc=4 vec=00000001 dout=12345678",
               n_ack, ack_cyc[0], ack_vec[0], ack_dout[0]);
    end
  endtask

  task automatic test_wrap_skip();
    rand_req(8'b0010_0000, 1);      // node 5 moves ptr to 6
    predict(0);
    run_batch(0);
    tests_run++;
    if (n_ack !== 1 || ack_vec[0] !== 8'b0010_0000) begin
      tests_failed++;
      $display("FAIL wrap_setup: n=%0d vec=%b, required n=1 vec=00100000", n_ack, ack_vec[0]);
    end
    rand_req(8'b1000_0010, 2);
    predict(0);
    run_batch(0);
    tests_run++;
    if (n_ack !== 2 || ack_vec[0] !== 8'b1000_0000 || ack_vec[1] !== 8'b0000_0010) begin
      tests_failed++;
      $display("FAIL wrap_order: n=%0d first=%b second=%b, required n=2 first=10000000 second=00000010",
               n_ack, ack_vec[0], ack_vec[1]);
    end
    for (int j = 0; j < ne && j < n_ack; j++) begin
      tests_run++;
      if (ack_cyc[j] !== e_ack[j] || ack_dout[j] !== e_dout[j]) begin
        tests_failed++;
        $display("FAIL wrap_ack%0d: cyc=%0d dout=%h, required cyc=%0d dout=%h",
                 j, ack_cyc[j], ack_dout[j], e_ack[j], e_dout[j]);
      end
    end
  endtask

  task automatic test_round_robin();
    pulse_reset();
    for (int r = 0; r < 2; r++) begin
      rand_req(8'hFF, 1);
      predict(0);
      run_batch(0);
      tests_run++;
      if (n_ack !== ne || n_iss !== ne) begin
        tests_failed++;
        $display("FAIL rr%0d_count: acks=%0d issues=%0d, required %0d each", r, n_ack, n_iss, ne);
      end
      for (int j = 0; j < ne && j < n_ack && j < n_iss; j++) begin
        tests_run++;
        if (ack_vec[j] !== (NODES'(1) << e_node[j]) || ack_cyc[j] !== e_ack[j] ||
            iss_cyc[j] !== e_iss[j] || iss_addr[j] !== req_addr[e_node[j]] || iss_din[j] !== req_din[e_node[j]]) begin
          tests_failed++;
          $display("FAIL rr%0d_txn%0d: vec=%b ack_cyc=%0d iss_cyc=%0d addr=%h din=%h, required vec=%b ack_cyc=%0d iss_cyc=%0d addr=%h din=%h",
                   r, j, ack_vec[j], ack_cyc[j], iss_cyc[j], iss_addr[j], iss_din[j],
                   NODES'(1) << e_node[j], e_ack[j], e_iss[j], req_addr[e_node[j]], req_din[e_node[j]]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 1; k < NI; k++) begin
      rand_req(8'b0010_0100, 0);
      predict(k);
      run_batch(k);
      tests_run++;
      if (n_ack !== 2 || n_iss !== 2 || ack_cyc[1] - ack_cyc[0] !== lat_of(k) + 3 || n_bcast_bad !== 0) begin
        tests_failed++;
        $display("FAIL b2b_lat%0d: acks=%0d issues=%0d spacing=%0d bcast_bad=%0d, required 2 2 %0d 0",
                 lat_of(k), n_ack, n_iss, ack_cyc[1] - ack_cyc[0], n_bcast_bad, lat_of(k) + 3);
      end
      for (int j = 0; j < ne && j < n_ack; j++) begin
        tests_run++;
        if (ack_vec[j] !== (NODES'(1) << e_node[j]) || ack_cyc[j] !== e_ack[j] || ack_dout[j] !== e_dout[j]) begin
          tests_failed++;
          $display("FAIL b2b_lat%0d_ack%0d: vec=%b cyc=%0d dout=%h, required vec=%b cyc=%0d dout=%h",
                   lat_of(k), j, ack_vec[j], ack_cyc[j], ack_dout[j], NODES'(1) << e_node[j], e_ack[j], e_dout[j]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 12; r++) begin
      int k = r % NI;
      rand_req(NODES'($urandom_range(1, 255)), 2);
      predict(k);
      run_batch(k);
      tests_run++;
      if (n_ack !== ne || n_iss !== ne || n_bcast_bad !== 0) begin
        tests_failed++;
        $display("FAIL rnd%0d_count: acks=%0d issues=%0d bcast_bad=%0d, required %0d %0d 0",
                 r, n_ack, n_iss, n_bcast_bad, ne, ne);
      end
      for (int j = 0; j < ne && j < n_ack && j < n_iss; j++) begin
        tests_run++;
        if (ack_vec[j] !== (NODES'(1) << e_node[j]) || ack_cyc[j] !== e_ack[j] || ack_dout[j] !== e_dout[j] ||
            iss_cyc[j] !== e_iss[j] || iss_addr[j] !== req_addr[e_node[j]] || iss_we[j] !== req_we[e_node[j]]) begin
          tests_failed++;
          $display("FAIL rnd%0d_txn%0d: vec=%b ack_cyc=%0d dout=%h iss_cyc=%0d addr=%h we=%b, required vec=%b ack_cyc=%0d dout=%h iss_cyc=%0d addr=%h we=%b",
                   r, j, ack_vec[j], ack_cyc[j], ack_dout[j], iss_cyc[j], iss_addr[j], iss_we[j],
                   NODES'(1) << e_node[j], e_ack[j], e_dout[j], e_iss[j], req_addr[e_node[j]], req_we[e_node[j]]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_read();
    rand_req(8'b0000_0100, 0);
    we_s[0] = req_we; addr_s[0] = req_addr; din_s[0] = req_din;
    en_s[0] = req_mask;
    repeat (2) @(negedge clk);      // cycle 2: first WAIT cycle
    #2 rst = 1'b0;
    #1;
    tests_run++;
    if (ack_s[0] !== '0 || dout_v[0] !== '0 || mem_en_s[0] !== 1'b0 || mem_we_s[0] !== 1'b0 ||
        mem_addr_s[0] !== '0 || mem_din_s[0] !== '0) begin
      tests_failed++;
      $display("FAIL midrd_reset: ack=%b en=%b we=%b addr=%h din=%h dout0=%h, required all zero",
               ack_s[0], mem_en_s[0], mem_we_s[0], mem_addr_s[0], mem_din_s[0], dout_v[0][0]);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int k = 0; k < NI; k++) begin exp_ptr[k] = 0; exp_dout[k] = '0; end
    predict(0);
    run_batch(0);
    tests_run++;
    if (n_ack !== 1 || n_iss !== 1 || ack_vec[0] !== 8'b0000_0100 || ack_cyc[0] !== e_ack[0] || ack_dout[0] !== e_dout[0]) begin
      tests_failed++;
      $display("FAIL midrd_retry: acks=%0d issues=%0d vec=%b cyc=%0d dout=%h, required 1 1 00000100 cyc=%0d dout=%h",
               n_ack, n_iss, ack_vec[0], ack_cyc[0], ack_dout[0], e_ack[0], e_dout[0]);
    end
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      en_s[k] = '0; we_s[k] = '0; addr_s[k] = '0; din_s[k] = '0;
      exp_ptr[k] = 0; exp_dout[k] = '0;
    end
    test_reset();
    test_single_write();
    test_single_read();
    test_wrap_skip();
    test_round_robin();
    test_back_to_back();
    test_random();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
